// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// levels, occupancy output, synchronous flush and standard or FWFT read mode.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            wr_en,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: FIFO_DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_LEVEL must be in 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_LEVEL must be in 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        almostfull  = (count >= AF_C);
        almostempty = (count <= AE_C);
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Explicit wrap keeps non-power-of-2 depths inside the array.
            if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) mem[wr_ptr] <= data_in;
    end

    if (FWFT) begin : g_fwft
        always_comb begin
            data_out   = mem[rd_ptr];
            data_valid = !empty;
        end
    end else begin : g_std
        // Flush drops the valid pulse but leaves the last read word on data_out.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out   <= '0;
                data_valid <= 1'b0;
            end else if (flush) begin
                data_valid <= 1'b0;
            end else if (rd_acc) begin
                data_out   <= mem[rd_ptr];
                data_valid <= 1'b1;
            end else begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Next-generation single-clock FIFO, generalised from the fixed-mode buffer used between stimulus and checker blocks.
- Adds the following to the existing FIFO behaviour:
  - arbitrary (non-power-of-2) depth;
  - programmable almost-full/almost-empty levels;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - occupancy output;
  - synchronous flush.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=2, any integer).
- AF_LEVEL, FIFO_DEPTH-1, almostfull asserted when count >= AF_LEVEL (1..FIFO_DEPTH).
- AE_LEVEL, 1, almostempty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of contents; flags and pointers as reset.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (FWFT: pop of head word).
- data_out  out  FIFO_WIDTH  read data.
- data_valid  out  1  standard: 1-cycle pulse, data_out updated; FWFT: head word present.
- wr_ack  out  1  registered; previous-cycle write accepted.
- overflow  out  1  registered; previous-cycle write rejected (FIFO full).
- underflow  out  1  registered; previous-cycle read rejected (FIFO empty).
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  count >= AF_LEVEL.
- almostempty  out  1  count <= AE_LEVEL.
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0;
  - wr_ack, overflow, underflow, data_valid (standard mode) all 0;
  - data_out=0 in standard mode;
  - full=0, empty=1, almostempty=(AE_LEVEL>=0)=1, almostfull=0.
- rst has priority over flush, which has priority over wr_en/rd_en.
- flush has the same effect as reset, except data_out holds its value in standard mode. Memory contents are not cleared.
- Write accept: wr_en && !full, evaluated on pre-edge count.
  - Writes mem[wr_ptr] and advances wr_ptr.
  - wr_ack=1, overflow=0 next cycle.
- Write reject: wr_en && full → overflow=1, wr_ack=0 next cycle. No state change.
- No write request: wr_ack=0, overflow=0.
- Read accept: rd_en && !empty, evaluated on pre-edge count. Advances rd_ptr, underflow=0.
- Read reject: rd_en && empty → underflow=1 next cycle.
- Pointer wrap: each pointer goes FIFO_DEPTH-1 → 0 exactly. It never indexes beyond FIFO_DEPTH-1, including for non-power-of-2 depths.
- Simultaneous wr_en && rd_en:
  - neither full nor empty: both accepted, count unchanged;
  - full: read only, count-1, overflow=1;
  - empty: write only, count+1, underflow=1.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. Never exceeds FIFO_DEPTH and never wraps below 0.
- full, empty, almostfull and almostempty are combinational from count.
- Standard mode (FWFT=0):
  - on read accept, data_out <= mem[rd_ptr] and data_valid=1 for one cycle;
  - otherwise data_out holds and data_valid=0;
  - latency is 1 cycle from rd_en to data.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty;
  - rd_en pops the head word;
  - a word written into an empty FIFO is visible one cycle after its write edge;
  - data_out is don't-care while empty.
- A read of the newest entry and a write in the same cycle never corrupt each other.
- Elaboration: an illegal FIFO_DEPTH, AF_LEVEL or AE_LEVEL triggers $fatal.

Test Plan:
- Reset/flags: assert rst → count=0, empty=1, almostempty=1, full=0, wr_ack=0, overflow=0, underflow=0, data_valid=0.
- Fill/overflow (DEPTH=5, AF_LEVEL=4, FWFT=0):
  - 5 writes of 0x0001..0x0005 → wr_ack each cycle, almostfull at count=4, full at 5;
  - 6th write → overflow=1, wr_ack=0, count stays 5.
- Drain/wrap/underflow (continuing): 5 reads → data_out 0x0001..0x0005 each one cycle after rd_en, with data_valid pulses; 6th read → underflow=1; then 3 more writes/reads confirm wr_ptr/rd_ptr wrap 4→0 with correct data order.
- Simultaneous ops:
  - count=2, wr_en=rd_en=1 → count=2, wr_ack=1, data_valid=1;
  - full and both → count=DEPTH-1, overflow=1;
  - empty and both → count=1, underflow=1.
- FWFT (FWFT=1): write 0xABCD into empty FIFO → next cycle data_valid=1, data_out=0xABCD with no rd_en; rd_en → empty=1, data_valid=0.
- Flush mid-operation: count=3, flush=1 with wr_en=1 → next cycle count=0, empty=1, wr_ack=0, write discarded; rst and flush together → reset behaviour.
